addr_fifo: RTL and testbench

- Address FIFO between the driver control register block (producer) and the address sequencer (consumer).
- Accepts 32-bit address words written by software through the control block's `addr_fifo_wr`/`addr_fifo_din` pulse.
- Stores them in a block RAM and hands them to the sequencer on request.
- Reports fill level, full/empty, threshold-based almost-full, and sticky overrun/underrun flags back to the control block's status register.

---
 rtl/driver_pkg.sv | 7 +
 rtl/addr_fifo_ram.sv | 26 ++
 rtl/addr_fifo.sv | 107 ++++++++++
 tb/tb_addr_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/driver_pkg.sv
// rtl/driver_pkg.sv - shared driver constants and address word type
package driver_pkg;
  localparam int ADDR_FIFO_DEPTH_DEFAULT  = 1024;
  localparam int ADDR_FIFO_THRESH_DEFAULT = 820;

  typedef logic [31:0] addr_word_t;
endpackage

// File: rtl/addr_fifo_ram.sv
// rtl/addr_fifo_ram.sv - simple dual-port RAM, one write port, registered read port
module addr_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a full FIFO pops and pushes the same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/addr_fifo.sv
// rtl/addr_fifo.sv - address FIFO between control register block and address sequencer
module addr_fifo
  import driver_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = ADDR_FIFO_DEPTH_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] addr_fifo_din,
  input  logic                  addr_fifo_wr,
  input  logic [15:0]           addr_fifo_threshold,
  input  logic                  clr,
  input  logic                  active_program,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [CNT_WIDTH-1:0]  words_in_addr_fifo,
  output logic                  addr_fifo_full,
  output logic                  addr_fifo_empty,
  output logic                  addr_fifo_almost_full,
  output logic                  addr_fifo_overrun,
  output logic                  addr_fifo_underrun
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, afull_q, afull_d;
  logic          overrun_q, overrun_d, underrun_q, underrun_d;
  logic          dout_valid_q, dout_valid_d;
  logic          rd_accept, wr_accept;

  always_comb begin
    rd_accept    = rd_en && !empty_q && !clr;
    wr_accept    = addr_fifo_wr && (!full_q || rd_accept) && !clr;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_valid_d = rd_accept;
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    overrun_d  = !clr && (overrun_q || (addr_fifo_wr && full_q && !rd_accept));
    underrun_d = !clr && (underrun_q || (rd_en && empty_q && active_program));
    empty_d    = (count_d == '0);
    full_d     = (count_d == (AW+1)'(DEPTH));
    afull_d    = 32'(count_d) >= 32'(addr_fifo_threshold);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  addr_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (addr_fifo_din),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  // A pop in flight is withheld when the flush lands in its delivery cycle.
  assign dout_valid            = dout_valid_q && !clr;
  assign words_in_addr_fifo    = CNT_WIDTH'(count_q);
  assign addr_fifo_full        = full_q;
  assign addr_fifo_empty       = empty_q;
  assign addr_fifo_almost_full = afull_q;
  assign addr_fifo_overrun     = overrun_q;
  assign addr_fifo_underrun    = underrun_q;
endmodule

// File: tb/tb_addr_fifo.sv
// tb/tb_addr_fifo.sv - self-checking bench for addr_fifo against a queue model
module tb_addr_fifo;
  import driver_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  addr_word_t  addr_fifo_din = '0;
  logic        addr_fifo_wr = 1'b0;
  logic [15:0] addr_fifo_threshold = 16'd12;
  logic        clr = 1'b0;
  logic        active_program = 1'b0;
  logic        rd_en = 1'b0;
  addr_word_t  dout;
  logic        dout_valid;
  logic [15:0] words_in_addr_fifo;
  logic        addr_fifo_full, addr_fifo_empty, addr_fifo_almost_full;
  logic        addr_fifo_overrun, addr_fifo_underrun;

  addr_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .addr_fifo_din(addr_fifo_din), .addr_fifo_wr(addr_fifo_wr),
    .addr_fifo_threshold(addr_fifo_threshold), .clr(clr), .active_program(active_program),
    .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .words_in_addr_fifo(words_in_addr_fifo),
    .addr_fifo_full(addr_fifo_full), .addr_fifo_empty(addr_fifo_empty),
    .addr_fifo_almost_full(addr_fifo_almost_full), .addr_fifo_overrun(addr_fifo_overrun),
    .addr_fifo_underrun(addr_fifo_underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  addr_word_t mq[$];
  addr_word_t got[$];
  addr_word_t m_dout = '0;
  bit m_vreg = 0, m_over = 0, m_under = 0, m_af = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_vreg = 0; m_over = 0; m_under = 0; m_af = 0;
  endtask

  // Advance one clock: update the model from the inputs the DUT just sampled.
  task automatic tick();
    bit rd_ok, wr_ok;
    int sz;
    @(posedge clk);
    sz = mq.size();
    if (!reset) model_reset();
    else begin
      if (clr) begin
        mq.delete(); m_over = 0; m_under = 0; m_vreg = 0;
      end else begin
        rd_ok  = rd_en && sz > 0;
        wr_ok  = addr_fifo_wr && (sz < DEPTH || rd_ok);
        m_vreg = rd_ok;
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(addr_fifo_din);
        if (addr_fifo_wr && !wr_ok) m_over = 1;
        if (rd_en && sz == 0 && active_program) m_under = 1;
      end
      m_af = mq.size() >= int'(addr_fifo_threshold);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("count", words_in_addr_fifo, mq.size());
      chk("empty", addr_fifo_empty, mq.size() == 0);
      chk("full", addr_fifo_full, mq.size() == DEPTH);
      chk("almost_full", addr_fifo_almost_full, m_af);
      chk("overrun", addr_fifo_overrun, m_over);
      chk("underrun", addr_fifo_underrun, m_under);
      chk("dout_valid", dout_valid, m_vreg && !clr);
      chk("dout", dout, m_dout);
      if (dout_valid) got.push_back(dout);
    end
  end

  task automatic wr(addr_word_t d);
    addr_fifo_wr = 1; addr_fifo_din = d; tick(); addr_fifo_wr = 0;
  endtask

  task automatic rd();
    rd_en = 1; tick(); rd_en = 0;
  endtask

  task automatic wr_rd(addr_word_t d);
    addr_fifo_wr = 1; addr_fifo_din = d; rd_en = 1; tick(); addr_fifo_wr = 0; rd_en = 0;
  endtask

  task automatic do_clr();
    clr = 1; tick(); clr = 0;
  endtask

  task automatic chk_reset_outputs(string nm);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_valid"}, dout_valid, 0);
    chk({nm, "_count"}, words_in_addr_fifo, 0);
    chk({nm, "_empty"}, addr_fifo_empty, 1);
    chk({nm, "_full"}, addr_fifo_full, 0);
    chk({nm, "_af"}, addr_fifo_almost_full, 0);
    chk({nm, "_over"}, addr_fifo_overrun, 0);
    chk({nm, "_under"}, addr_fifo_underrun, 0);
  endtask

  initial begin
    bit seen;
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1;

    // Five words round-trip in order
    for (int i = 0; i < 5; i++) wr(32'h100 + i);
    chk("t1_count", words_in_addr_fifo, 5);
    chk("t1_empty", addr_fifo_empty, 0);
    got.delete();
    for (int i = 0; i < 5; i++) begin
      rd();
      chk("t1_valid_next", dout_valid, 1);
    end
    tick();
    chk("t1_n", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t1_data", got[i], 32'h100 + i);
    chk("t1_empty_end", addr_fifo_empty, 1);

    // Threshold, full, concurrent write/read at full, dropped write
    for (int i = 0; i < 11; i++) wr(i);
    chk("t2_af_11", addr_fifo_almost_full, 0);
    wr(11);
    chk("t2_af_12", addr_fifo_almost_full, 1);
    for (int i = 12; i < 16; i++) wr(i);
    chk("t2_full", addr_fifo_full, 1);
    got.delete();
    wr_rd(32'hAA);
    chk("t3_count", words_in_addr_fifo, 16);
    chk("t3_over", addr_fifo_overrun, 0);
    wr(32'hDEAD);
    chk("t2_over", addr_fifo_overrun, 1);
    chk("t2_count", words_in_addr_fifo, 16);
    for (int i = 0; i < 16; i++) rd();
    tick();
    chk("t3_n", got.size(), 17);
    if (got.size() == 17) begin
      chk("t3_oldest", got[0], 0);
      chk("t3_last", got[16], 32'hAA);
    end
    seen = 0;
    foreach (got[i]) if (got[i] == 32'hDEAD) seen = 1;
    chk("t2_no_dead", seen, 0);

    // Underrun qualification and no bypass when empty
    do_clr();
    rd();
    chk("t4_under_idle", addr_fifo_underrun, 0);
    active_program = 1;
    rd();
    chk("t4_under_act", addr_fifo_underrun, 1);
    chk("t4_valid", dout_valid, 0);
    do_clr();
    wr_rd(32'h42);
    chk("t4_wr_count", words_in_addr_fifo, 1);
    chk("t4_wr_under", addr_fifo_underrun, 1);
    rd();

    // Flush with a concurrent write; flush suppresses an in-flight pop
    for (int i = 0; i < 17; i++) wr(32'h300 + i);
    for (int i = 0; i < 9; i++) rd();
    chk("t5_count7", words_in_addr_fifo, 7);
    chk("t5_flags", {addr_fifo_overrun, addr_fifo_underrun}, 2'b11);
    rd();
    clr = 1; addr_fifo_wr = 1; addr_fifo_din = 32'h77;
    #1 chk("t5_suppress", dout_valid, 0);
    tick();
    clr = 0; addr_fifo_wr = 0;
    chk("t5_count0", words_in_addr_fifo, 0);
    chk("t5_flags_clr", {addr_fifo_overrun, addr_fifo_underrun}, 0);
    got.delete();
    wr(32'h55);
    rd();
    tick();
    chk("t5_rt_n", got.size(), 1);
    if (got.size() == 1) chk("t5_rt", got[0], 32'h55);

    // Wrap-around streaming at occupancy 4
    active_program = 0;
    addr_fifo_threshold = 16'd20;
    do_clr();
    got.delete();
    for (int i = 0; i < 4; i++) wr(i);
    for (int i = 4; i < 40; i++) wr_rd(i);
    for (int i = 0; i < 4; i++) rd();
    tick();
    chk("t6_n", got.size(), 40);
    for (int i = 0; i < 40 && i < got.size(); i++) chk("t6_order", got[i], i);
    chk("t6_flags", {addr_fifo_overrun, addr_fifo_underrun, addr_fifo_almost_full}, 0);

    // Asynchronous reset with a pop in flight
    for (int i = 0; i < 3; i++) wr(32'h500 + i);
    rd();
    #2 reset = 0;
    #1 chk_reset_outputs("mid_rst");
    model_reset();
    tick();
    reset = 1;
    addr_fifo_threshold = 16'd0;
    tick();
    chk("thr0_af", addr_fifo_almost_full, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      addr_fifo_wr   = $urandom_range(0, 1);
      rd_en          = $urandom_range(0, 99) < 45;
      clr            = $urandom_range(0, 63) == 0;
      active_program = $urandom_range(0, 1);
      addr_fifo_din  = $urandom;
      if ($urandom_range(0, 49) == 0) addr_fifo_threshold = 16'($urandom_range(0, 18));
      tick();
    end
    addr_fifo_wr = 0; rd_en = 0; clr = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
